ten_thirty: RTL and testbench
=============================

# ten_thirty

Single-player "ten and a half" card game controller for the FPGA board top level. The player draws cards against a dealer from a fixed internal deck using two push-buttons. Both hands are shown on two 4-digit seven-segment groups, and the round result is shown on three LEDs. All logic runs on one clock; the game FSM advances on a divided-clock enable tick.

## Interface
- DIV_BIT, 4: counter bit defining the game tick; one tick every 2^(DIV_BIT+1) = 32 clk cycles.
- SCAN_BIT, 16: LSB of the 2-bit display scan index (counter[SCAN_BIT+1:SCAN_BIT]).
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-high (despite the suffix).
- btn_m  in  1  middle button: start round / hit (draw a card).
- btn_r  in  1  right button: stand.
- seg7_sel  out  8  digit select, active-high; bits[3:0] right group, bits[7:4] left group.
- seg7  out  8  right-group segments {dp,g,f,e,d,c,b,a}, active-high; shows the player.
- seg7_l  out  8  left-group segments, same encoding; shows the dealer.
- led  out  3  result: [0] player wins, [1] dealer wins, [2] tie.

## Operation
- Free-running 25-bit counter; tick = counter[DIV_BIT:0] all ones (1-clk pulse).
- Buttons are sampled only on tick into prev registers. Edge = sample & ~prev.
- If both buttons have an edge on the same tick, btn_m wins and btn_r is ignored.
- Deck: 16-entry ROM of ranks, indexed by 4-bit ptr (reset 0, wraps 15->0, never reset between rounds). Every dealt card increments ptr.
  - Ranks, index 0..15: 1,5,11,3,10,13,2,7,12,4,6,9,8,1,10,3.
- Card value is in half-units: rank 1–10 -> 2*rank; rank 11–13 -> 1 (0.5).
- Hand totals are 6-bit half-units. Bust means total > 21 (over 10.5).
- Each hand holds at most 5 cards (3-bit count per hand).
- FSM states: IDLE, PLAYER, DEALER, DONE.
  - IDLE: btn_m -> clear both hands, deal one player card, go to PLAYER. btn_r is ignored.
  - PLAYER: btn_m -> deal player card. btn_r -> deal one dealer card, go to DEALER.
  - PLAYER bust -> DONE immediately, dealer wins.
  - PLAYER 5th card without bust -> auto-stand, same as btn_r.
  - DEALER: btn_m -> deal dealer card. btn_r -> DONE and compare.
  - DEALER bust -> DONE, player wins. 5th card without bust -> DONE and compare.
  - Compare: higher total wins; equal totals -> tie.
  - DONE: btn_m -> clear hands, deal player card, go to PLAYER. btn_r is ignored.
- led is 3'b000 except in DONE, where it is one-hot with the result.
- Display:
  - Scan index i = counter[SCAN_BIT+1:SCAN_BIT]; seg7_sel = {1<<i, 1<<i}.
  - Per group, digit 3 = card count, digit 2 = blank, digit 1 = tens of integer total (blank if 0), digit 0 = ones of integer total, with dp lit when the total is odd (.5).
  - In IDLE all digits are blank (segments 0).
  - Hex-to-segment font: standard 0–9.

## Timing
- Reset, asynchronous: counter=0, ptr=0, state=IDLE, hands/counts=0, prev=0, led=0, seg7_sel=0, seg7=0, seg7_l=0.
- On release, the first tick occurs at clk cycle 32.
- A card is dealt, the state changes and led updates on the clk edge of the tick detecting the button edge.
- Display outputs are registered and reflect the new state one clk later.
- A button must be held across at least one tick to register. Holding it longer gives no repeat; a new press needs a release seen at a tick.
- Reset mid-round returns to IDLE immediately; the deck pointer also returns to 0.

## Test plan
- Reset check: assert rst_n, then release -> all outputs 0, state IDLE; btn_r press in IDLE -> no change.
- Full round:
  - btn_m -> player total 1.0 (2 half-units), count 1.
  - btn_r -> dealer 5.0.
  - btn_m -> dealer J, total 5.5 with dp lit.
  - btn_r -> DONE, led=3'b010.
  - Extra btn_r -> no change.
  - btn_m -> new round, player card rank 3, total 3.0, led=0, ptr=4.
- Player bust: from reset, keep pressing btn_m -> totals 1, 6, 6.5, 9.5, then rank 10 -> 19.5, bust, DONE, led=3'b010 without a dealer card.
- Dealer bust/player win: preload ptr via reset plus a sequence so the dealer exceeds 10.5 -> led=3'b001.
- Simultaneous btn_m/btn_r rising on the same tick in PLAYER -> only a hit occurs, state stays PLAYER.
- Short press (<32 clk, between ticks) -> ignored. Held button over 10 ticks -> exactly one card dealt.

Source files
------------

// File: rtl/ten_thirty.sv
// "Ten and a half" card game controller: player vs dealer on a fixed 16-card deck,
// two buttons sampled on a divided tick, two scanned 4-digit displays and result LEDs.
module ten_thirty #(
  parameter int unsigned DIV_BIT  = 4,
  parameter int unsigned SCAN_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_m,
  input  logic       btn_r,
  output logic [7:0] seg7_sel,
  output logic [7:0] seg7,
  output logic [7:0] seg7_l,
  output logic [2:0] led
);

  typedef enum logic [1:0] {StIdle, StPlayer, StDealer, StDone} state_e;

  localparam logic [2:0] ResPlayer = 3'b001;
  localparam logic [2:0] ResDealer = 3'b010;
  localparam logic [2:0] ResTie    = 3'b100;

  state_e      state_q, state_d;
  logic [24:0] counter_q, counter_d;
  logic        prev_m_q, prev_m_d, prev_r_q, prev_r_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [5:0]  p_tot_q, p_tot_d, d_tot_q, d_tot_d;
  logic [2:0]  p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
  logic [2:0]  result_q, result_d;
  logic [7:0]  sel_q, sel_d, seg_p_q, seg_p_d, seg_d_q, seg_d_d;

  logic        tick, hit, stand;
  logic [1:0]  scan_idx;
  logic [5:0]  card0, card1, p_sum, d_sum;

  function automatic logic [3:0] rank_of(input logic [3:0] idx);
    logic [3:0] r;
    case (idx)
      4'd0:    r = 4'd1;
      4'd1:    r = 4'd5;
      4'd2:    r = 4'd11;
      4'd3:    r = 4'd3;
      4'd4:    r = 4'd10;
      4'd5:    r = 4'd13;
      4'd6:    r = 4'd2;
      4'd7:    r = 4'd7;
      4'd8:    r = 4'd12;
      4'd9:    r = 4'd4;
      4'd10:   r = 4'd6;
      4'd11:   r = 4'd9;
      4'd12:   r = 4'd8;
      4'd13:   r = 4'd1;
      4'd14:   r = 4'd10;
      default: r = 4'd3;
    endcase
    return r;
  endfunction

  // Values are in half-units: face cards count as one half.
  function automatic logic [5:0] card_val(input logic [3:0] rank);
    return (rank > 4'd10) ? 6'd1 : {1'b0, rank, 1'b0};
  endfunction

  function automatic logic [2:0] compare(input logic [5:0] p, input logic [5:0] d);
    if (p > d) return ResPlayer;
    else if (d > p) return ResDealer;
    else return ResTie;
  endfunction

  function automatic logic [6:0] font(input logic [4:0] d);
    logic [6:0] s;
    case (d)
      5'd0:    s = 7'h3f;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5b;
      5'd3:    s = 7'h4f;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6d;
      5'd6:    s = 7'h7d;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7f;
      5'd9:    s = 7'h6f;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] digit(input logic idle, input logic [2:0] cnt,
                                       input logic [5:0] tot, input logic [1:0] idx);
    logic [4:0] whole, tens, rem;
    logic [7:0] res;
    whole = tot[5:1];
    if (whole >= 5'd20) begin
      tens = 5'd2;
      rem  = whole - 5'd20;
    end else if (whole >= 5'd10) begin
      tens = 5'd1;
      rem  = whole - 5'd10;
    end else begin
      tens = 5'd0;
      rem  = whole;
    end
    case (idx)
      2'd3:    res = {1'b0, font({2'b00, cnt})};
      2'd2:    res = 8'h00;
      2'd1:    res = (tens == 5'd0) ? 8'h00 : {1'b0, font(tens)};
      default: res = {tot[0], font(rem)};
    endcase
    return idle ? 8'h00 : res;
  endfunction

  assign tick     = &counter_q[DIV_BIT:0];
  assign scan_idx = counter_q[SCAN_BIT+1:SCAN_BIT];
  // A simultaneous stand edge is dropped in favour of the hit.
  assign hit      = tick & btn_m & ~prev_m_q;
  assign stand    = tick & btn_r & ~prev_r_q & ~hit;

  assign card0 = card_val(rank_of(ptr_q));
  assign card1 = card_val(rank_of(ptr_q + 4'd1));
  assign p_sum = p_tot_q + card0;
  assign d_sum = d_tot_q + card0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= StIdle;
      counter_q <= '0;
      prev_m_q  <= 1'b0;
      prev_r_q  <= 1'b0;
      ptr_q     <= '0;
      p_tot_q   <= '0;
      d_tot_q   <= '0;
      p_cnt_q   <= '0;
      d_cnt_q   <= '0;
      result_q  <= '0;
      sel_q     <= '0;
      seg_p_q   <= '0;
      seg_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      prev_m_q  <= prev_m_d;
      prev_r_q  <= prev_r_d;
      ptr_q     <= ptr_d;
      p_tot_q   <= p_tot_d;
      d_tot_q   <= d_tot_d;
      p_cnt_q   <= p_cnt_d;
      d_cnt_q   <= d_cnt_d;
      result_q  <= result_d;
      sel_q     <= sel_d;
      seg_p_q   <= seg_p_d;
      seg_d_q   <= seg_d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q + 25'd1;
    prev_m_d  = tick ? btn_m : prev_m_q;
    prev_r_d  = tick ? btn_r : prev_r_q;
    ptr_d     = ptr_q;
    p_tot_d   = p_tot_q;
    d_tot_d   = d_tot_q;
    p_cnt_d   = p_cnt_q;
    d_cnt_d   = d_cnt_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (hit) begin
          p_tot_d  = card0;
          p_cnt_d  = 3'd1;
          d_tot_d  = '0;
          d_cnt_d  = '0;
          ptr_d    = ptr_q + 4'd1;
          result_d = '0;
          state_d  = StPlayer;
        end
      end
      StPlayer: begin
        if (hit) begin
          p_tot_d = p_sum;
          p_cnt_d = p_cnt_q + 3'd1;
          ptr_d   = ptr_q + 4'd1;
          if (p_sum > 6'd21) begin
            result_d = ResDealer;
            state_d  = StDone;
          end else if (p_cnt_q == 3'd4) begin
            // Fifth card stands automatically: the next deck card goes to the dealer.
            d_tot_d = card1;
            d_cnt_d = 3'd1;
            ptr_d   = ptr_q + 4'd2;
            state_d = StDealer;
          end
        end else if (stand) begin
          d_tot_d = d_sum;
          d_cnt_d = d_cnt_q + 3'd1;
          ptr_d   = ptr_q + 4'd1;
          state_d = StDealer;
        end
      end
      StDealer: begin
        if (hit) begin
          d_tot_d = d_sum;
          d_cnt_d = d_cnt_q + 3'd1;
          ptr_d   = ptr_q + 4'd1;
          if (d_sum > 6'd21) begin
            result_d = ResPlayer;
            state_d  = StDone;
          end else if (d_cnt_q == 3'd4) begin
            result_d = compare(p_tot_q, d_sum);
            state_d  = StDone;
          end
        end else if (stand) begin
          result_d = compare(p_tot_q, d_tot_q);
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    led     = (state_q == StDone) ? result_q : 3'b000;
    sel_d   = {4'b0001 << scan_idx, 4'b0001 << scan_idx};
    seg_p_d = digit(state_q == StIdle, p_cnt_q, p_tot_q, scan_idx);
    seg_d_d = digit(state_q == StIdle, d_cnt_q, d_tot_q, scan_idx);
  end

  assign seg7_sel = sel_q;
  assign seg7     = seg_p_q;
  assign seg7_l   = seg_d_q;

endmodule

// File: tb/tb_ten_thirty.sv
// Directed bench for ten_thirty: table of button presses with expected hands/LEDs,
// plus hand-written short-press, long-hold and simultaneous-press sequences.
module tb_ten_thirty;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_m = 1'b0;
  logic       btn_r = 1'b0;
  logic [7:0] seg7_sel, seg7, seg7_l;
  logic [2:0] led;

  int total = 0;
  int bad = 0;
  int pe = 0;

  logic [7:0] p_dig[4];
  logic [7:0] d_dig[4];

  typedef struct {
    bit         do_rst;
    bit         m;
    bit         r;
    int         pc;
    int         pt;
    int         dc;
    int         dt;
    logic [2:0] led;
    bit         idle;
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  // Posedges since reset release; ticks land on edges that make pe a multiple of 32.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) pe <= 0;
    else pe <= pe + 1;
  end

  ten_thirty #(.DIV_BIT(4), .SCAN_BIT(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_m    (btn_m),
    .btn_r    (btn_r),
    .seg7_sel (seg7_sel),
    .seg7     (seg7),
    .seg7_l   (seg7_l),
    .led      (led)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_font(input int d);
    case (d)
      0: return 8'h3f;
      1: return 8'h06;
      2: return 8'h5b;
      3: return 8'h4f;
      4: return 8'h66;
      5: return 8'h6d;
      6: return 8'h7d;
      7: return 8'h07;
      8: return 8'h7f;
      9: return 8'h6f;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_digit(input bit idle, input int cnt, input int tot,
                                           input int idx);
    int w;
    w = tot / 2;
    if (idle) return 8'h00;
    case (idx)
      3: return exp_font(cnt);
      2: return 8'h00;
      1: return (w / 10 == 0) ? 8'h00 : exp_font(w / 10);
      default: return exp_font(w % 10) | ((tot % 2 == 1) ? 8'h80 : 8'h00);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    btn_m = 1'b0;
    btn_r = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sel", int'(seg7_sel), 0);
    check("rst_seg7", int'(seg7), 0);
    check("rst_seg7_l", int'(seg7_l), 0);
    check("rst_led", int'(led), 0);
    rst_n = 1'b0;
  endtask

  task automatic press(input bit m, input bit r);
    @(negedge clk);
    btn_m = m;
    btn_r = r;
    repeat (40) @(negedge clk);
    btn_m = 1'b0;
    btn_r = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic read_disp();
    bit ok;
    bit seen[4];
    int idx;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 1'b0;
      p_dig[i] = 8'hee;
      d_dig[i] = 8'hee;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      case (seg7_sel[3:0])
        4'b0001: idx = 0;
        4'b0010: idx = 1;
        4'b0100: idx = 2;
        4'b1000: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0 || seg7_sel[7:4] != seg7_sel[3:0]) ok = 1'b0;
      else begin
        seen[idx] = 1'b1;
        p_dig[idx] = seg7;
        d_dig[idx] = seg7_l;
      end
    end
    for (int i = 0; i < 4; i++) if (!seen[i]) ok = 1'b0;
    check("sel_scan", int'(ok), 1);
  endtask

  task automatic check_state(input string tag, input bit idle, input int pc, input int pt,
                             input int dc, input int dt, input logic [2:0] eled);
    check({tag, "_led"}, int'(led), int'(eled));
    read_disp();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_p%0d", tag, i), int'(p_dig[i]), int'(exp_digit(idle, pc, pt, i)));
      check($sformatf("%s_d%0d", tag, i), int'(d_dig[i]), int'(exp_digit(idle, dc, dt, i)));
    end
  endtask

  initial begin
    // do_rst, m, r, player cnt/tot, dealer cnt/tot (half-units), led, idle
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0,  3'b000, 1};
    vecs[1]  = '{0, 0, 1, 0, 0,  0, 0,  3'b000, 1};
    vecs[2]  = '{0, 1, 0, 1, 2,  0, 0,  3'b000, 0};
    vecs[3]  = '{0, 0, 1, 1, 2,  1, 10, 3'b000, 0};
    vecs[4]  = '{0, 1, 0, 1, 2,  2, 11, 3'b000, 0};
    vecs[5]  = '{0, 0, 1, 1, 2,  2, 11, 3'b010, 0};
    vecs[6]  = '{0, 0, 1, 1, 2,  2, 11, 3'b010, 0};
    vecs[7]  = '{0, 1, 0, 1, 6,  0, 0,  3'b000, 0};
    vecs[8]  = '{0, 1, 0, 2, 26, 0, 0,  3'b010, 0};
    vecs[9]  = '{1, 1, 0, 1, 2,  0, 0,  3'b000, 0};
    vecs[10] = '{0, 1, 0, 2, 12, 0, 0,  3'b000, 0};
    vecs[11] = '{0, 1, 0, 3, 13, 0, 0,  3'b000, 0};
    vecs[12] = '{0, 1, 0, 4, 19, 0, 0,  3'b000, 0};
    vecs[13] = '{0, 1, 0, 5, 39, 0, 0,  3'b010, 0};
    vecs[14] = '{1, 1, 0, 1, 2,  0, 0,  3'b000, 0};
    vecs[15] = '{0, 0, 1, 1, 2,  1, 10, 3'b000, 0};
    vecs[16] = '{0, 1, 0, 1, 2,  2, 11, 3'b000, 0};
    vecs[17] = '{0, 1, 0, 1, 2,  3, 17, 3'b000, 0};
    vecs[18] = '{0, 1, 0, 1, 2,  4, 37, 3'b001, 0};
    vecs[19] = '{0, 1, 0, 1, 1,  0, 0,  3'b000, 0};

    for (int v = 0; v < 20; v++) begin
      if (vecs[v].do_rst) do_reset();
      if (vecs[v].m || vecs[v].r) press(vecs[v].m, vecs[v].r);
      else repeat (40) @(negedge clk);
      check_state($sformatf("vec%0d", v), vecs[v].idle, vecs[v].pc, vecs[v].pt,
                  vecs[v].dc, vecs[v].dt, vecs[v].led);
    end

    // Short press between two ticks must be ignored.
    do_reset();
    for (int k = 0; k < 40 && (pe % 32) != 2; k++) @(negedge clk);
    check("short_phase", pe % 32, 2);
    btn_m = 1'b1;
    repeat (20) @(negedge clk);
    btn_m = 1'b0;
    repeat (40) @(negedge clk);
    check_state("short", 1, 0, 0, 0, 0, 3'b000);

    // Held over ten ticks deals exactly once; a fresh press deals again.
    btn_m = 1'b1;
    repeat (330) @(negedge clk);
    btn_m = 1'b0;
    repeat (40) @(negedge clk);
    check_state("hold", 0, 1, 2, 0, 0, 3'b000);
    press(1, 0);
    check_state("hold2", 0, 2, 12, 0, 0, 3'b000);

    // Mid-round reset restarts the deck; simultaneous press is a hit only.
    do_reset();
    press(1, 0);
    check_state("sim0", 0, 1, 2, 0, 0, 3'b000);
    press(1, 1);
    check_state("sim1", 0, 2, 12, 0, 0, 3'b000);
    press(0, 1);
    check_state("sim2", 0, 2, 12, 1, 1, 3'b000);
    press(0, 1);
    check_state("sim3", 0, 2, 12, 1, 1, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
